// File: rtl/sa_arbiter_pkg.sv
// sa_arbiter shared definitions.
// Operand widths, defaults and FSM states.
package sa_arbiter_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 32;
  localparam int Y_W         = 10;
  localparam int X_W         = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/sa_arbiter_if.sv
// Requester and solver signals of sa_arbiter.
// slave = arbiter side, master = environment.
interface sa_arbiter_if #(
  parameter int N_REQ = sa_arbiter_pkg::N_REQ_DEF
);
  import sa_arbiter_pkg::*;

  logic [N_REQ-1:0]     req;
  logic [Y_W*N_REQ-1:0] req_y;
  logic [N_REQ-1:0]     ack;
  logic [X_W-1:0]       res_x;
  logic                 err;
  logic                 sa_enable;
  logic [Y_W-1:0]       sa_target_y;
  logic                 sa_done;
  logic [X_W-1:0]       sa_x;

  modport slave (
    input  req, req_y, sa_done, sa_x,
    output ack, res_x, err, sa_enable, sa_target_y
  );

  modport master (
    output req, req_y, sa_done, sa_x,
    input  ack, res_x, err, sa_enable, sa_target_y
  );

endinterface

// File: rtl/sa_arbiter_rr_pick.sv
// Round-robin picker: first set req bit
// above last_grant, wrapping. Combinational.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [IW-1:0]    grant,
  output logic             valid
);

  int idx;

  // scan upward from last_grant+1, keep the first hit
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_grant) + k) % N_REQ;
      if (!valid && req[idx]) begin
        grant = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sa_arbiter.sv
// Shares one successive-approximation solver
// between N_REQ round-robin requesters.
module sa_arbiter
  import sa_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic         clk,
  input logic         rst_n,
  sa_arbiter_if.slave bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0] LAST_RST = IW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [X_W-1:0]   res_x_q, res_x_d;
  logic             err_q, err_d;
  logic             sa_en_q, sa_en_d;
  logic [Y_W-1:0]   tgt_q, tgt_d;

  logic [IW-1:0]    pick_idx;
  logic             pick_vld;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req        (bus.req),
    .last_grant (last_q),
    .grant      (pick_idx),
    .valid      (pick_vld)
  );

  // next state and registered outputs
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    ack_d   = '0;
    res_x_d = '0;
    err_d   = 1'b0;
    sa_en_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          tgt_d   = bus.req_y[int'(pick_idx)*Y_W +: Y_W];
          sa_en_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.sa_done) begin
          res_x_d          = bus.sa_x;
          ack_d[grant_q]   = 1'b1;
          state_d          = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          err_d            = 1'b1;
          ack_d[grant_q]   = 1'b1;
          state_d          = S_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
      tgt_q   <= '0;
      ack_q   <= '0;
      res_x_q <= '0;
      err_q   <= 1'b0;
      sa_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ack_q   <= ack_d;
      res_x_q <= res_x_d;
      err_q   <= err_d;
      sa_en_q <= sa_en_d;
    end
  end

  assign bus.ack         = ack_q;
  assign bus.res_x       = res_x_q;
  assign bus.err         = err_q;
  assign bus.sa_enable   = sa_en_q;
  assign bus.sa_target_y = tgt_q;

endmodule

// File: tb/tb_sa_arbiter.sv
// Randomized bench for sa_arbiter with a
// behavioural requester/solver scoreboard.
`timescale 1ns/1ps
module tb_sa_arbiter;
  import sa_arbiter_pkg::*;

  localparam int N = 4;
  localparam int T = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sa_arbiter_if #(.N_REQ(N)) bus ();

  sa_arbiter #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [N-1:0]   req_i;
  logic [Y_W-1:0] y [N];
  logic           sa_done_i;
  logic [X_W-1:0] sa_x_i;

  assign bus.req     = req_i;
  assign bus.sa_done = sa_done_i;
  assign bus.sa_x    = sa_x_i;
  for (genvar g = 0; g < N; g++) begin : g_y
    assign bus.req_y[Y_W*g +: Y_W] = y[g];
  end

  int n_chk, n_bad;
  int sol_mode, sol_cnt, sol_lat;
  logic [Y_W-1:0] sol_y;
  bit busy;
  int exp_g, mdl_last, cyc, exp_cyc, exp_x, exp_err, n_en;
  int last_x, last_err;
  int order[$];
  logic [N-1:0] rearm_mask;
  int rearm_left;

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // solver law: largest x with 300 + 2.4x <= y
  function automatic int f_x(int yy);
    int v;
    if (yy < 300) return 0;
    v = (yy - 300) * 5 / 12;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int rr_ref(logic [N-1:0] r, int last);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  // mode 0 normal, 1 never done, 2 done stuck high
  task automatic solver();
    if (!rst_n) begin
      sol_cnt = 0;
      sa_done_i = 1'b0;
      return;
    end
    case (sol_mode)
      0: begin
        sa_done_i = 1'b0;
        if (sol_cnt > 0) begin
          sol_cnt--;
          if (sol_cnt == 0) begin
            sa_done_i = 1'b1;
            sa_x_i = 8'(f_x(int'(sol_y)));
          end
        end
        if (bus.sa_enable) begin
          sol_y = bus.sa_target_y;
          sol_lat = $urandom_range(1, 6);
          sol_cnt = sol_lat;
        end
      end
      1: sa_done_i = 1'b0;
      default: begin
        sa_done_i = 1'b1;
        if (bus.sa_enable) begin
          sol_y = bus.sa_target_y;
          sa_x_i = 8'(f_x(int'(sol_y)));
        end
      end
    endcase
  endtask

  task automatic monitor(logic [N-1:0] rq);
    int g;
    if (!rst_n) begin
      busy = 0;
      mdl_last = N - 1;
      return;
    end
    if (busy) cyc++;
    if (bus.ack != 0) begin
      g = -1;
      for (int i = 0; i < N; i++) if (bus.ack[i]) g = i;
      chk("ack_busy", int'(busy), 1);
      chk("ack_vec", int'(bus.ack), 1 << exp_g);
      chk("ack_lat", cyc, exp_cyc);
      chk("res_x", int'(bus.res_x), exp_x);
      chk("err", int'(bus.err), exp_err);
      order.push_back(g);
      last_x = int'(bus.res_x);
      last_err = int'(bus.err);
      mdl_last = exp_g;
      busy = 0;
      if (rearm_mask[g] && rearm_left > 0) rearm_left--;
      else req_i[g] = 1'b0;
    end
    if (bus.sa_enable) begin
      chk("overlap", int'(busy), 0);
      exp_g = rr_ref(rq, mdl_last);
      chk("grant_vld", int'(exp_g >= 0), 1);
      if (exp_g < 0) exp_g = 0;
      chk("tgt_y", int'(bus.sa_target_y), int'(y[exp_g]));
      exp_x = (sol_mode == 1) ? 0 : f_x(int'(y[exp_g]));
      exp_err = (sol_mode == 1) ? 1 : 0;
      exp_cyc = (sol_mode == 1) ? T + 1 :
                (sol_mode == 2) ? 2 : sol_lat + 1;
      busy = 1;
      cyc = 0;
      n_en++;
    end
  endtask

  task automatic tick();
    logic [N-1:0] rq;
    rq = req_i;
    @(negedge clk);
    solver();
    monitor(rq);
  endtask

  task automatic wait_idle(int max);
    int k;
    k = 0;
    while ((req_i != 0 || busy) && k < max) begin
      tick();
      k++;
    end
    chk("wait_bound", int'(req_i != 0 || busy), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int e0, raised, k;
    n_chk = 0; n_bad = 0;
    rst_n = 1'b0; req_i = '0;
    for (int i = 0; i < N; i++) y[i] = '0;
    sa_done_i = 1'b0; sa_x_i = '0;
    sol_mode = 0; sol_cnt = 0; sol_lat = 1; sol_y = '0;
    busy = 0; mdl_last = N - 1; n_en = 0;
    exp_g = 0; cyc = 0; exp_cyc = 0; exp_x = 0; exp_err = 0;
    rearm_mask = '0; rearm_left = 0;
    repeat (3) tick();
    chk("rst_ack", int'(bus.ack), 0);
    chk("rst_res", int'(bus.res_x), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_en", int'(bus.sa_enable), 0);
    chk("rst_tgt", int'(bus.sa_target_y), 0);
    rst_n = 1'b1;
    tick();

    // single request, y=600
    y[0] = 10'd600; req_i = 4'b0001;
    order.delete(); e0 = n_en;
    wait_idle(100);
    chk("s_cnt", order.size(), 1);
    if (order.size() >= 1) chk("s_grant", order[0], 0);
    chk("s_x", last_x, 125);
    chk("s_err", last_err, 0);
    chk("s_en", n_en - e0, 1);

    // all four after reset
    do_reset();
    for (int i = 0; i < N; i++) y[i] = 10'd540;
    req_i = 4'b1111; order.delete(); e0 = n_en;
    wait_idle(200);
    chk("all_en", n_en - e0, 4);
    chk("all_cnt", order.size(), 4);
    if (order.size() == 4)
      for (int i = 0; i < 4; i++) chk("all_ord", order[i], i);
    chk("all_x", last_x, 100);

    // 1 and 3 re-arm immediately
    y[1] = 10'd400; y[3] = 10'd1000;
    rearm_mask = 4'b1010; rearm_left = 6;
    req_i = 4'b1010; order.delete();
    wait_idle(500);
    rearm_mask = '0;
    chk("alt_cnt", order.size(), 8);
    if (order.size() == 8)
      for (int i = 0; i < 8; i++)
        chk("alt_ord", order[i], (i % 2 == 0) ? 1 : 3);

    // request dropped mid-operation
    y[2] = 10'd333; req_i = 4'b0100; order.delete();
    k = 0;
    while (!busy && k < 20) begin tick(); k++; end
    chk("drop_start", int'(busy), 1);
    req_i[2] = 1'b0;
    wait_idle(100);
    chk("drop_cnt", order.size(), 1);
    if (order.size() >= 1) chk("drop_g", order[0], 2);

    // solver never finishes
    sol_mode = 1;
    y[1] = 10'd700; req_i = 4'b0010;
    wait_idle(200);
    chk("to_err", last_err, 1);
    chk("to_x", last_x, 0);
    sol_mode = 0;
    y[2] = 10'd900; req_i = 4'b0100;
    wait_idle(100);
    chk("post_to_x", last_x, 250);
    chk("post_to_err", last_err, 0);

    // sa_done stuck high in IDLE/START
    sol_mode = 2;
    repeat (3) begin
      tick();
      chk("idle_ack", int'(bus.ack), 0);
      chk("idle_en", int'(bus.sa_enable), 0);
    end
    y[2] = 10'd660; req_i = 4'b0100;
    wait_idle(100);
    chk("force_x", last_x, 150);
    sol_mode = 0;
    tick();

    // async reset during WAIT
    sol_mode = 1;
    y[2] = 10'd777; req_i = 4'b0100;
    k = 0;
    while (!(busy && cyc >= 3) && k < 30) begin tick(); k++; end
    chk("ar_wait", int'(busy && cyc >= 3), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ack", int'(bus.ack), 0);
    chk("ar_res", int'(bus.res_x), 0);
    chk("ar_err", int'(bus.err), 0);
    chk("ar_en", int'(bus.sa_enable), 0);
    chk("ar_tgt", int'(bus.sa_target_y), 0);
    tick();
    tick();
    rst_n = 1'b1;
    sol_mode = 0;
    y[0] = 10'd420; y[3] = 10'd540;
    req_i = req_i | 4'b1001; order.delete();
    wait_idle(200);
    if (order.size() >= 1) chk("ar_first", order[0], 0);
    chk("ar_cnt", order.size(), 3);

    // random traffic
    order.delete(); raised = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, N - 1);
        if (!req_i[k]) begin
          y[k] = 10'($urandom_range(0, 1023));
          req_i[k] = 1'b1;
          raised++;
        end
      end
      tick();
    end
    wait_idle(2000);
    chk("rnd_cnt", order.size(), raised);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sa_arbiter.md
SA_ARBITER -- requirements
Module: sa_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one successive-approximation solver.
REQ-002 Parameter TIMEOUT, default 32: maximum WAIT cycles before abort.
REQ-003 clk  input  1  the single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester request, level, held until ack.
REQ-006 req_y  input  10*N_REQ  requester i target_y at bits [10i+9:10i]; stable while req[i] high.
REQ-007 ack  output  N_REQ  one-hot, one-cycle completion pulse to the granted requester.
REQ-008 res_x  output  8  solver result; valid only while ack is non-zero.
REQ-009 err  output  1  timeout flag; valid only while ack is non-zero.
REQ-010 sa_enable  output  1  one-cycle start pulse to the solver.
REQ-011 sa_target_y  output  10  operand to the solver, held constant from START until leaving WAIT.
REQ-012 sa_done  input  1  solver completion pulse.
REQ-013 sa_x  input  8  solver result, sampled when sa_done is high.

Function
REQ-014 FSM states IDLE, START, WAIT, RESP; all outputs registered.
REQ-015 IDLE: if any req bit set, grant the first set bit searching upward from last_grant+1, wrapping modulo N_REQ; latch grant index and its req_y into sa_target_y; go to START; else stay.
REQ-016 START: sa_enable=1 for exactly this cycle; clear timeout counter; go to WAIT.
REQ-017 WAIT: sa_done=1 -> capture sa_x, err_next=0, go to RESP.
REQ-018 WAIT: counter increments each cycle without sa_done; at TIMEOUT-1 -> res_x_next=0, err_next=1, go to RESP.
REQ-019 sa_done and timeout in the same cycle: sa_done wins, err=0.
REQ-020 RESP: ack[grant]=1, res_x and err driven for exactly one cycle; last_grant<=grant; go to IDLE.
REQ-021 Requester deasserts req on the edge it samples ack; a requester re-asserting immediately is regranted only if no other requester is pending.
REQ-022 req[i] dropped mid-operation: operation completes and ack[i] is still pulsed.
REQ-023 sa_done outside WAIT is ignored.
REQ-024 Minimum cycles from grant to ack: 3 + solver latency; no overlap of operations.
REQ-025 Timeout counter width clog2(TIMEOUT); saturates, never wraps.

Reset
REQ-026 rst_n low asynchronously forces IDLE, last_grant=N_REQ-1 (so requester 0 wins first), ack=0, res_x=0, err=0, sa_enable=0, sa_target_y=0, counter=0.
REQ-027 Reset mid-operation abandons the operation; no ack is issued for it.

Structure
REQ-028 Shared package holds the FSM state enumeration, N_REQ and TIMEOUT defaults, and the 10-bit/8-bit operand widths.
REQ-029 Round-robin priority pick is one sub-module, rr_pick (inputs req, last_grant; outputs grant index, valid), purely combinational.
REQ-030 The solver is instantiated outside this block; sa_arbiter only drives and samples its ports.

Verification
REQ-031 req[0]=1, y=600, real solver -> one sa_enable pulse with sa_target_y=600, then ack=4'b0001 for one cycle, res_x=125, err=0.
REQ-032 All four req high in the same cycle after reset, y=540 each -> acks in order 0,1,2,3, each res_x=100, sa_enable pulses 4 times.
REQ-033 req[1] and req[3] re-asserted immediately after every ack -> grants alternate 1,3,1,3 for 8 operations; 0 and 2 never acked.
REQ-034 Stub solver never asserts sa_done -> ack[grant] exactly TIMEOUT cycles after WAIT entry, err=1, res_x=0; next request is served normally.
REQ-035 rst_n pulsed low during WAIT -> all outputs 0 immediately without a clock edge, no ack for the aborted request, next req starts from requester 0.
REQ-036 sa_done forced high in IDLE and START -> no state change, no ack.
